// File: rtl/arb_pkg.sv
// arb_pkg: shared constants, state encoding and small helpers for the
// 4-way round-robin arbiter.
//   N_REQ        : number of requesters
//   IDX_W        : width of a requester index
//   MAX_HOLD_DEF : default grant hold limit, in cycles
//   HOLD_W       : width of the hold counter; covers MAX_HOLD up to 255
package arb_pkg;

  localparam int N_REQ        = 4;
  localparam int IDX_W        = 2;
  localparam int MAX_HOLD_DEF = 15;
  localparam int HOLD_W       = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Binary index to one-hot grant vector.
  function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/prio_enc_4_2.sv
// prio_enc_4_2: combinational 4-to-2 priority encoder, lowest index wins.
//   in  : 4-bit input vector
//   idx : index of the lowest set bit (0 when nothing is set)
//   any : high when at least one bit of in is set
module prio_enc_4_2
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] in,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = |in;
    casez (in)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: 4-requester round-robin arbiter with a bounded hold time.
//   clk       : clock, all registers update on the rising edge
//   rst_n     : asynchronous active-low reset
//   req       : level-sensitive request lines, held while the resource is needed
//   gnt       : registered one-hot grant
//   gnt_idx   : binary index of the active grant, 0 when idle
//   gnt_valid : high exactly when gnt is non-zero
//   timeout   : one-cycle pulse when a grant is forcibly revoked
// A grant lasts until its requester drops req or until MAX_HOLD cycles have
// elapsed. Either way the arbiter spends one IDLE cycle before the next grant,
// and the search pointer moves just past the last winner.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  state_t             state, state_nx;
  logic [IDX_W-1:0]   ptr, ptr_nx;
  logic [HOLD_W-1:0]  hold_cnt, hold_nx;
  logic [N_REQ-1:0]   gnt_nx;
  logic [IDX_W-1:0]   idx_nx;
  logic               vld_nx, to_nx;

  // Rotate right by ptr so the encoder's lowest-index priority becomes
  // "first set bit at or after ptr"; adding ptr back undoes the rotation.
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]   enc_idx, win_idx;
  logic               enc_any;

  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: N_REQ];
  assign win_idx = enc_idx + ptr;

  prio_enc_4_2 u_enc (
    .in  (req_rot),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    hold_nx  = hold_cnt;
    gnt_nx   = gnt;
    idx_nx   = gnt_idx;
    vld_nx   = gnt_valid;
    to_nx    = 1'b0;
    case (state)
      IDLE: begin
        hold_nx = '0;
        gnt_nx  = '0;
        idx_nx  = '0;
        vld_nx  = 1'b0;
        if (enc_any) begin
          state_nx = GRANT;
          hold_nx  = HOLD_W'(1);
          gnt_nx   = idx2onehot(win_idx);
          idx_nx   = win_idx;
          vld_nx   = 1'b1;
        end
      end
      GRANT: begin
        // Release takes precedence over the hold limit: no timeout when the
        // owner lets go in the same cycle the limit is reached.
        if (!req[gnt_idx] || hold_cnt >= HOLD_LIM) begin
          state_nx = IDLE;
          ptr_nx   = gnt_idx + IDX_W'(1);
          hold_nx  = '0;
          gnt_nx   = '0;
          idx_nx   = '0;
          vld_nx   = 1'b0;
          to_nx    = req[gnt_idx];
        end else begin
          hold_nx = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        hold_nx  = '0;
        gnt_nx   = '0;
        idx_nx   = '0;
        vld_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      hold_cnt  <= hold_nx;
      gnt       <= gnt_nx;
      gnt_idx   <= idx_nx;
      gnt_valid <= vld_nx;
      timeout   <= to_nx;
    end
  end

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter MAX_HOLD, default 15: the maximum number of consecutive cycles one grant may be held; legal range 1..255.
REQ-003 Port clk, input, 1 bit: clock; every register updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port req, input, 4 bits: request lines; req[i] is level-sensitive and held by requester i for as long as it needs the resource.
REQ-006 Port gnt, output, 4 bits: one-hot grant, registered.
REQ-007 Port gnt_idx, output, 2 bits: binary index of the asserted gnt bit (4-to-2 encoding of gnt); 0 when no grant is active.
REQ-008 Port gnt_valid, output, 1 bit: high exactly when gnt is non-zero.
REQ-009 Port timeout, output, 1 bit: one-cycle pulse marking a forced revocation.

Function
REQ-010 The block SHALL have two states: IDLE and GRANT.
REQ-011 In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0.
REQ-012 In IDLE with req != 0, the winner SHALL be the first set bit found when searching indices ptr, ptr+1, ptr+2, ptr+3, each taken mod 4.
REQ-013 The winner SHALL appear on gnt, gnt_idx and gnt_valid at the next rising edge, so req-to-gnt latency is 1 cycle, and the state SHALL become GRANT.
REQ-014 In GRANT, gnt, gnt_idx and gnt_valid SHALL hold constant, and changes on the other req bits SHALL have no effect.
REQ-015 hold_cnt SHALL be 1 in the first GRANT cycle and increment by 1 each GRANT cycle; it saturates at MAX_HOLD and is cleared in IDLE.
REQ-016 Release: if req[gnt_idx] is 0 during a GRANT cycle, the next edge SHALL clear gnt, set ptr to (gnt_idx+1) mod 4 and enter IDLE.
REQ-017 Revocation: if req[gnt_idx] is 1 and hold_cnt == MAX_HOLD, the next edge SHALL clear gnt, set ptr to (gnt_idx+1) mod 4, enter IDLE and pulse timeout high for exactly 1 cycle.
REQ-018 If release and hold_cnt == MAX_HOLD occur in the same cycle, the block SHALL treat it as a release, with no timeout pulse.
REQ-019 Every grant SHALL be followed by exactly one IDLE cycle before the next grant, so back-to-back grants are separated by one cycle.
REQ-020 ptr SHALL wrap from 3 to 0.
REQ-021 Any requester held high SHALL be granted within 3 x (MAX_HOLD+1) + 1 cycles.
REQ-022 At every clock edge, gnt SHALL be either zero or one-hot, and gnt_idx SHALL equal the encoded value of gnt.

Reset
REQ-023 rst_n low SHALL immediately, without waiting for a clock edge, force: gnt = 0, gnt_idx = 0, gnt_valid = 0, timeout = 0, ptr = 0, hold_cnt = 0, state = IDLE.
REQ-024 Reset asserted during GRANT SHALL drop the grant immediately, and the first arbitration after release SHALL start from ptr = 0.
REQ-025 The first rising edge with rst_n high SHALL evaluate req as in IDLE.

Structure
REQ-026 Shared package arb_pkg SHALL hold: N_REQ = 4, IDX_W = 2, the state enum (IDLE, GRANT) and the default MAX_HOLD constant.
REQ-027 Sub-module prio_enc_4_2 SHALL be a combinational 4-to-2 priority encoder (lowest index wins) with an any-set flag.
REQ-028 The arbiter SHALL apply prio_enc_4_2 to req rotated right by ptr, then add ptr mod 4 to the result.
REQ-029 Registered logic SHALL cover only state, ptr, hold_cnt, gnt, gnt_idx, gnt_valid and timeout.

Verification
REQ-030 Reset, then req = 4'b1111 held with each granted requester dropping its req after 2 cycles -> gnt sequence 0001, 0010, 0100, 1000, 0001, with one zero cycle between grants.
REQ-031 ptr = 2 (after granting 1), then req = 4'b0011 -> gnt = 0001 (wrap past indices 2 and 3), gnt_idx = 0.
REQ-032 MAX_HOLD = 4, req = 4'b0100 held -> gnt = 0100 for 4 cycles, then 0 with timeout = 1 for 1 cycle, then regranted with gnt = 0100.
REQ-033 MAX_HOLD = 4, req[2] dropped in the 4th GRANT cycle -> gnt clears with timeout = 0.
REQ-034 rst_n pulsed low mid-grant between clock edges -> outputs 0 before the next edge; with req = 4'b1010 after reset -> gnt = 0010.
REQ-035 Random req for 10k cycles -> a checker confirms REQ-021 and REQ-022 on every cycle and that gnt is never asserted while in IDLE.
